// File: rtl/instr_fetch_unit.sv
// Non-pipelined instruction fetch: one request per instruction, the fetched word held for decode
// until it is accepted; the next PC is either sequential or the redirect target.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        VALID = 2'b10
    } state_t;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] seq_pc;
    logic        fetch_done;
    logic        accept;

    // Outputs depend only on registered state, so imem_* never reaches decode combinationally.
    assign seq_pc     = pc_q + 32'd4;
    assign fetch_done = (state_q == FETCH) && imem_ack;
    assign accept     = (state_q == VALID) && instr_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (fetch_done) begin
                    instr_d = imem_rdata;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (accept) begin
                    pc_d    = redirect ? (redirect_target & WORD_MASK) : seq_pc;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign instr_valid = (state_q == VALID);
    assign pc          = pc_q;
    assign pc_plus4    = seq_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, zero-wait and delayed fetches, stall, redirect,
// async reset mid-fetch, and PC wrap on a second instance.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_ack, instr_valid, instr_ready, redirect;
    logic [31:0] imem_addr, imem_rdata, instr, redirect_target, pc, pc_plus4;
    logic [5:0]  opcode;

    logic        imem_req1, imem_ack1, instr_valid1, instr_ready1, redirect1;
    logic [31:0] imem_addr1, imem_rdata1, instr1, redirect_target1, pc1, pc_plus41;
    logic [5:0]  opcode1;

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) u0 (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_target(redirect_target), .pc(pc), .pc_plus4(pc_plus4)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u1 (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req1), .imem_addr(imem_addr1), .imem_ack(imem_ack1), .imem_rdata(imem_rdata1),
        .instr(instr1), .opcode(opcode1), .instr_valid(instr_valid1), .instr_ready(instr_ready1),
        .redirect(redirect1), .redirect_target(redirect_target1), .pc(pc1), .pc_plus4(pc_plus41)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_target = '0;
        imem_ack1 = 1'b0; imem_rdata1 = '0; instr_ready1 = 1'b0;
        redirect1 = 1'b0; redirect_target1 = '0;
        tick; tick;

        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_opcode", opcode, 6'b000000);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        chk("rst_u1_pc", pc1, 32'hFFFF_FFFC);
        chk("rst_u1_pc_plus4", pc_plus41, 32'h0);

        #3 rst_n = 1'b1;
        #1 chk("idle_req", imem_req, 0);
        tick;
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 32'h0);
        chk("first_valid", instr_valid, 0);

        imem_ack = 1'b1; imem_rdata = 32'h8C08_0004; instr_ready = 1'b1;
        tick;
        imem_ack = 1'b0;
        chk("lw_valid", instr_valid, 1);
        chk("lw_opcode", opcode, 6'b100011);
        chk("lw_pc", pc, 32'h0);
        chk("lw_req", imem_req, 0);
        tick;
        instr_ready = 1'b0;
        chk("next_req", imem_req, 1);
        chk("next_addr", imem_addr, 32'h4);
        chk("next_valid", instr_valid, 0);

        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", imem_req, 0);
        chk("arst_valid", instr_valid, 0);
        chk("arst_pc", pc, 32'h0);
        chk("arst_instr", instr, 32'h0);
        tick;
        chk("arst_late_ack_req", imem_req, 0);
        chk("arst_late_ack_instr", instr, 32'h0);
        imem_ack = 1'b0;
        #2 rst_n = 1'b1;
        tick;
        chk("refetch_req", imem_req, 1);
        chk("refetch_addr", imem_addr, 32'h0);

        tick;
        chk("sw_wait_req", imem_req, 1);
        chk("sw_wait_valid", instr_valid, 0);
        imem_ack = 1'b1; imem_rdata = 32'hAC08_0008;
        tick;
        imem_ack = 1'b0;
        chk("sw_valid", instr_valid, 1);
        chk("sw_opcode", opcode, 6'b101011);
        chk("sw_pc", pc, 32'h0);

        for (int i = 0; i < 5; i++) begin
            redirect = (i % 2 == 0);
            redirect_target = 32'h0000_0100;
            tick;
            chk("stall_valid", instr_valid, 1);
            chk("stall_instr", instr, 32'hAC08_0008);
            chk("stall_opcode", opcode, 6'b101011);
            chk("stall_pc", pc, 32'h0);
            chk("stall_req", imem_req, 0);
        end

        redirect = 1'b0; instr_ready = 1'b1;
        tick;
        instr_ready = 1'b0;
        chk("beq_req", imem_req, 1);
        chk("beq_addr", imem_addr, 32'h4);

        redirect = 1'b1; redirect_target = 32'h0000_0200;
        tick; tick;
        redirect = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h1109_0002;
        tick;
        imem_ack = 1'b0;
        chk("beq_opcode", opcode, 6'b000100);
        chk("beq_pc", pc, 32'h4);
        chk("beq_valid", instr_valid, 1);

        instr_ready = 1'b1;
        tick;
        instr_ready = 1'b0;
        chk("addi_addr", imem_addr, 32'h8);
        tick; tick;
        imem_ack = 1'b1; imem_rdata = 32'h2108_0001;
        tick;
        imem_ack = 1'b0;
        chk("addi_opcode", opcode, 6'b001000);
        chk("addi_pc", pc, 32'h8);
        chk("addi_pc_plus4", pc_plus4, 32'hC);

        redirect = 1'b1; redirect_target = 32'h0000_0043; instr_ready = 1'b1;
        tick;
        redirect = 1'b0; instr_ready = 1'b0;
        chk("redir_req", imem_req, 1);
        chk("redir_addr", imem_addr, 32'h0000_0040);

        imem_ack = 1'b1; imem_rdata = 32'h0000_0000;
        tick;
        imem_ack = 1'b0;
        chk("redir_valid", instr_valid, 1);
        chk("redir_pc", pc, 32'h0000_0040);
        instr_ready = 1'b1;
        tick;
        instr_ready = 1'b0;
        chk("redir_seq_addr", imem_addr, 32'h0000_0044);

        chk("wrap_req", imem_req1, 1);
        chk("wrap_addr", imem_addr1, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc_plus41, 32'h0);
        imem_ack1 = 1'b1; imem_rdata1 = 32'h0800_0000;
        tick;
        imem_ack1 = 1'b0;
        chk("wrap_valid", instr_valid1, 1);
        chk("wrap_opcode", opcode1, 6'b000010);
        chk("wrap_pc", pc1, 32'hFFFF_FFFC);
        chk("wrap_valid_pc_plus4", pc_plus41, 32'h0);
        instr_ready1 = 1'b1;
        tick;
        instr_ready1 = 1'b0;
        chk("wrap_next_addr", imem_addr1, 32'h0);
        chk("wrap_next_pc_plus4", pc_plus41, 32'h4);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Sequential instruction source for the MIPS core.
- Fetches 32-bit words from instruction memory over a req/ack handshake and holds each fetched instruction stable for the decode stage.
- Presents instr[31:26] as the opcode for the main decoder.
- Accepts the decoder/datapath control-flow result (branch taken / jump) as a redirect of the next PC.
- Sits between the instruction memory and the main decoder; it drives the decoder's opcode input.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset. Bits [1:0] must be 00.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  byte address of the fetch; equals pc.
- imem_ack  input  1  memory has read data on imem_rdata this cycle.
- imem_rdata  input  32  instruction word, sampled only when imem_req & imem_ack.
- instr  output  32  held instruction word.
- opcode  output  6  instr[31:26], feeds the main decoder.
- instr_valid  output  1  instr/opcode/pc are valid for decode.
- instr_ready  input  1  decode stage consumes the instruction this cycle.
- redirect  input  1  next PC comes from redirect_target. Sampled only on accept.
- redirect_target  input  32  branch/jump target address.
- pc  output  32  address of the held or in-flight instruction.
- pc_plus4  output  32  pc + 4, modulo 2^32.

Behaviour:
- States: IDLE, FETCH, VALID. 2-bit registered state.
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE, pc=RESET_PC, instr=32'h0.
  - imem_req=0, instr_valid=0.
  - opcode=6'b000000, pc_plus4=RESET_PC+4.
- IDLE: lasts exactly one clock after reset release, then goes to FETCH. imem_req=0 in IDLE.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held constant until ack.
  - On the edge where imem_ack=1: instr <= imem_rdata, state <= VALID.
  - Zero-wait memory (ack in the first FETCH cycle) is legal.
  - instr_valid=0 in FETCH.
- VALID:
  - instr_valid=1, imem_req=0. instr, opcode and pc are held stable until accept.
- Accept = instr_valid & instr_ready, on that edge:
  - redirect=1: pc <= {redirect_target[31:2], 2'b00}. Low bits are forced to zero, no fault.
  - redirect=0: pc <= pc + 4.
  - state <= FETCH.
- redirect and redirect_target are ignored in all other cycles: IDLE, FETCH, and VALID without ready.
- imem_ack outside FETCH is ignored. The memory must not assert ack while imem_req=0.
- Throughput: minimum 2 cycles per instruction (1 FETCH with zero-wait ack, then 1 VALID with ready). There is no prefetch or overlap.
- PC wrap: 32'hFFFF_FFFC + 4 -> 32'h0000_0000. pc_plus4 wraps the same way.
- Reset mid-FETCH or mid-VALID:
  - The outstanding request is abandoned; imem_req drops asynchronously.
  - The fetch restarts from RESET_PC via IDLE.
- Outputs instr, opcode, pc and instr_valid are registered or pure decodes of registered state; there is no combinational path from imem_* to them.
- opcode is a continuous slice of instr.

Test Plan:
- Reset/start: RESET_PC=0, zero-wait memory returning 32'h8C08_0004 (lw), instr_ready=1 -> first imem_req on the 2nd clock after rst_n rise, imem_addr=0. Next cycle instr_valid=1, opcode=6'b100011, pc=0. The following fetch uses addr=4.
- Sequential stream: memory returns sw 32'hAC08_0008, beq 32'h1109_0002, addi 32'h2108_0001 at addrs 0/4/8, ack delayed 2 cycles -> opcodes 101011, 000100, 001000 in order. Each instruction stays valid until ready. pc=0,4,8.
- Backpressure: hold instr_ready=0 for 5 cycles in VALID -> instr, opcode and pc unchanged, imem_req=0 throughout. Toggling redirect=1 during the stall has no effect.
- Redirect: at pc=8 accept with redirect=1, redirect_target=32'h0000_0043 -> next imem_addr=32'h0000_0040. Following sequential fetch addr=32'h0000_0044.
- Wrap: RESET_PC=32'hFFFF_FFFC, accept without redirect -> next imem_addr=0. pc_plus4 was 0 while pc=FFFF_FFFC.
- Async reset mid-fetch: assert rst_n=0 mid-cycle while imem_req=1 and ack pending -> imem_req and instr_valid go 0 immediately (before the next edge). After release, the refetch starts at RESET_PC. A late ack during reset changes nothing.
